// File: rtl/pe_pkg.sv
// Shared constants and pass-state encoding for the FP32 dot-product PE interface.
package pe_pkg;

    localparam int PE_LANES   = 5;
    localparam int FP32_W     = 32;
    localparam int PE_VEC_W   = PE_LANES * FP32_W;
    localparam int PE_LATENCY = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        P0   = 2'd1,
        P1   = 2'd2
    } pe_pass_e;

endpackage

// File: rtl/pe_result_fifo.sv
// Synchronous result FIFO with first-word-fall-through head taken straight from storage.
module pe_result_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_empty,
    output logic             o_full
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wptr;
    logic [AW:0]      r_rptr;
    logic             w_doPop;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign o_empty = (r_wptr == r_rptr);
    assign o_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign o_data  = o_empty ? '0 : r_mem[r_rptr[AW-1:0]];
    assign w_doPop = i_pop && !o_empty;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (i_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_doPop) begin
                r_rptr <= r_rptr + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (i_push) begin
            r_mem[r_wptr[AW-1:0]] <= i_data;
        end
    end

endmodule

// File: rtl/pe_fp32_feeder.sv
// Drives the two-beat PE operand protocol, tracks the fixed PE pipeline and buffers
// results; issue is credit-gated so a finished result always has a FIFO slot.
module pe_fp32_feeder
    import pe_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int PE_LATENCY = pe_pkg::PE_LATENCY
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                s_valid,
    output logic                s_ready,
    input  logic [PE_VEC_W-1:0] s_a,
    input  logic [PE_VEC_W-1:0] s_b,
    output logic [PE_VEC_W-1:0] pe_a,
    output logic [PE_VEC_W-1:0] pe_b,
    output logic                pe_cntr,
    input  logic [FP32_W-1:0]   pe_out,
    output logic                m_valid,
    input  logic                m_ready,
    output logic [FP32_W-1:0]   m_data,
    output logic                idle
);

    localparam int CW = $clog2(FIFO_DEPTH + 1);

    pe_pass_e              r_state;
    pe_pass_e              w_next;
    logic [PE_VEC_W-1:0]   r_a;
    logic [PE_VEC_W-1:0]   r_b;
    logic                  r_cntr;
    logic [PE_LATENCY-1:0] r_tag;
    logic [CW-1:0]         r_credits;
    logic                  w_accept;
    logic                  w_pop;
    logic                  w_push;
    logic                  w_empty;
    logic                  w_full;

    assign s_ready  = rst_n && (r_state != P0) && (r_credits < CW'(FIFO_DEPTH));
    assign w_accept = s_valid && s_ready;
    assign w_pop    = m_valid && m_ready;
    assign w_push   = r_tag[PE_LATENCY-1];
    assign m_valid  = !w_empty;
    assign idle     = (r_credits == '0) && (r_state == IDLE);
    assign pe_a     = r_a;
    assign pe_b     = r_b;
    assign pe_cntr  = r_cntr;

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_next = P0;
            P0:      w_next = P1;
            P1:      w_next = w_accept ? P0 : IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Operands are held until the next accept; the pass select follows next-state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_a       <= '0;
            r_b       <= '0;
            r_cntr    <= 1'b0;
            r_tag     <= '0;
            r_credits <= '0;
        end else begin
            r_state <= w_next;
            r_cntr  <= (w_next == P1);
            if (w_accept) begin
                r_a <= s_a;
                r_b <= s_b;
            end
            r_tag <= {r_tag[PE_LATENCY-2:0], (r_state == P1)};
            case ({w_accept, w_pop})
                2'b10:   r_credits <= r_credits + CW'(1);
                2'b01:   r_credits <= r_credits - CW'(1);
                default: r_credits <= r_credits;
            endcase
        end
    end

    pe_result_fifo #(
        .DEPTH(FIFO_DEPTH),
        .WIDTH(FP32_W)
    ) u_fifo (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_push (w_push),
        .i_data (pe_out),
        .i_pop  (w_pop),
        .o_data (m_data),
        .o_empty(w_empty),
        .o_full (w_full)
    );

    // Credit gating guarantees a pipeline result never lands on a full FIFO.
    assert property (@(posedge clk) disable iff (!rst_n) !(w_push && w_full));

endmodule

// File: tb/tb_pe_fp32_feeder.sv
// Self-checking bench for pe_fp32_feeder with a behavioural 4-stage PE and a result scoreboard.
module tb_pe_fp32_feeder;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         s_valid;
    logic         s_ready;
    logic [159:0] s_a;
    logic [159:0] s_b;
    logic [159:0] pe_a;
    logic [159:0] pe_b;
    logic         pe_cntr;
    logic [31:0]  pe_out;
    logic         m_valid;
    logic         m_ready;
    logic [31:0]  m_data;
    logic         idle;

    int errorCount = 0;
    int checkCount = 0;
    int cyc = 0;
    int lastPop = -100;
    bit headSeen = 0;
    logic [31:0] curExp = '0;
    logic [31:0] expQ [$];
    int          accQ [$];
    logic [31:0] pePipe [4];

    pe_fp32_feeder #(.FIFO_DEPTH(4), .PE_LATENCY(4)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .s_valid(s_valid),
        .s_ready(s_ready),
        .s_a    (s_a),
        .s_b    (s_b),
        .pe_a   (pe_a),
        .pe_b   (pe_b),
        .pe_cntr(pe_cntr),
        .pe_out (pe_out),
        .m_valid(m_valid),
        .m_ready(m_ready),
        .m_data (m_data),
        .idle   (idle)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    function automatic real f2r(input logic [31:0] x);
        logic [63:0] d;
        if (x[30:23] == 8'd0) return 0.0;
        d = {x[31], 11'(x[30:23]) + 11'd896, x[22:0], 29'd0};
        return $bitstoreal(d);
    endfunction

    function automatic logic [31:0] r2f(input real r);
        logic [63:0] d;
        if (r == 0.0) return 32'h0;
        d = $realtobits(r);
        return {d[63], 8'(d[62:52] - 11'd896), d[51:29]};
    endfunction

    function automatic logic [159:0] vec5(input logic [31:0] l0, input logic [31:0] l1);
        return {96'd0, l1, l0};
    endfunction

    // Behavioural PE: the pass-1 beat yields the dot product four edges later.
    always @(posedge clk) begin
        real acc;
        acc = 0.0;
        for (int i = 0; i < 5; i++) acc += f2r(pe_a[32*i +: 32]) * f2r(pe_b[32*i +: 32]);
        pePipe[0] <= pe_cntr ? r2f(acc) : 32'hDEADBEEF;
        for (int i = 1; i < 4; i++) pePipe[i] <= pePipe[i-1];
    end
    assign pe_out = pePipe[3];

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", tag, actual, expected, cyc);
        end
    endtask

    // Scoreboard: record accepts, compare every visible result against the queue head.
    always @(negedge clk) begin
        int expFirst;
        if (rst_n) begin
            if (s_valid && s_ready) begin
                expQ.push_back(curExp);
                accQ.push_back(cyc);
            end
            if (m_valid) begin
                if (expQ.size() == 0) begin
                    checkOutput("unexpected m_valid", {31'd0, m_valid}, 32'd0);
                end else begin
                    if (!headSeen) begin
                        expFirst = (accQ[0] + 7 > lastPop + 1) ? accQ[0] + 7 : lastPop + 1;
                        checkOutput("first valid cycle", cyc, expFirst);
                        headSeen = 1;
                    end
                    checkOutput("m_data", m_data, expQ[0]);
                    if (m_ready) begin
                        void'(expQ.pop_front());
                        void'(accQ.pop_front());
                        headSeen = 0;
                        lastPop = cyc;
                    end
                end
            end
        end
    end

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [159:0] a, input logic [159:0] b,
                                 input logic [31:0] expv, output int accCyc);
        bit got;
        s_valid = 1'b1;
        s_a     = a;
        s_b     = b;
        curExp  = expv;
        accCyc  = -1;
        for (int t = 0; t < 60; t++) begin
            @(negedge clk);
            got = s_ready;
            nextCycle();
            if (got) begin
                accCyc = cyc - 1;
                break;
            end
        end
        if (accCyc < 0) checkOutput("accept timeout", 32'd0, 32'd1);
    endtask

    task automatic waitIdle();
        bit seen;
        seen = 0;
        for (int t = 0; t < 60 && !seen; t++) begin
            @(negedge clk);
            seen = idle;
            nextCycle();
        end
        checkOutput("idle reached", {31'd0, seen}, 32'd1);
    endtask

    task automatic holdOffCheck(input string tag, input int n);
        for (int t = 0; t < n; t++) begin
            @(negedge clk);
            checkOutput(tag, {31'd0, s_ready}, 32'd0);
            nextCycle();
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int acc;
        int prevAcc;
        logic [31:0] kVal [6];
        kVal[0] = 32'h00000000; kVal[1] = 32'h3F800000; kVal[2] = 32'h40000000;
        kVal[3] = 32'h40400000; kVal[4] = 32'h40800000; kVal[5] = 32'h40A00000;

        rst_n = 1'b0; s_valid = 1'b1; s_a = '1; s_b = '1; m_ready = 1'b1;
        repeat (3) nextCycle();
        @(negedge clk);
        checkOutput("reset s_ready", {31'd0, s_ready}, 32'd0);
        checkOutput("reset m_valid", {31'd0, m_valid}, 32'd0);
        checkOutput("reset m_data", m_data, 32'd0);
        checkOutput("reset idle", {31'd0, idle}, 32'd1);
        checkOutput("reset pe_cntr", {31'd0, pe_cntr}, 32'd0);
        checkOutput("reset pe_a zero", {31'd0, |pe_a}, 32'd0);
        checkOutput("reset pe_b zero", {31'd0, |pe_b}, 32'd0);
        nextCycle();
        s_valid = 1'b0;
        rst_n = 1'b1;
        nextCycle();

        $display("[TB] single op");
        applyStimulus({5{32'h3F800000}}, {5{32'h40000000}}, 32'h41200000, acc);
        s_valid = 1'b0;
        checkOutput("pe_cntr pass0", {31'd0, pe_cntr}, 32'd0);
        checkOutput("pe_a lane4 loaded", pe_a[159:128], 32'h3F800000);
        checkOutput("idle busy", {31'd0, idle}, 32'd0);
        nextCycle();
        checkOutput("pe_cntr pass1", {31'd0, pe_cntr}, 32'd1);
        checkOutput("pe_b lane0 held", pe_b[31:0], 32'h40000000);
        nextCycle();
        checkOutput("pe_cntr back to 0", {31'd0, pe_cntr}, 32'd0);
        waitIdle();

        $display("[TB] back-to-back");
        prevAcc = 0;
        for (int k = 0; k < 6; k++) begin
            applyStimulus(vec5(kVal[k], 32'd0), vec5(32'h3F800000, 32'd0), kVal[k], acc);
            if (k > 0) checkOutput("accept spacing", acc - prevAcc, 32'd2);
            prevAcc = acc;
        end
        s_valid = 1'b0;
        waitIdle();

        $display("[TB] backpressure");
        m_ready = 1'b0;
        for (int k = 0; k < 4; k++)
            applyStimulus(vec5(kVal[k], 32'd0), vec5(32'h3F800000, 32'd0), kVal[k], acc);
        s_a = vec5(kVal[4], 32'd0); s_b = vec5(32'h3F800000, 32'd0); curExp = kVal[4];
        holdOffCheck("s_ready held low when full", 10);
        m_ready = 1'b1;
        nextCycle();
        m_ready = 1'b0;
        @(negedge clk);
        checkOutput("s_ready after one pop", {31'd0, s_ready}, 32'd1);
        nextCycle();
        s_a = vec5(kVal[5], 32'd0); curExp = kVal[5];
        holdOffCheck("s_ready low after refill", 6);
        m_ready = 1'b1;
        applyStimulus(vec5(kVal[5], 32'd0), vec5(32'h3F800000, 32'd0), kVal[5], acc);
        s_valid = 1'b0;
        waitIdle();

        $display("[TB] simultaneous accept and pop");
        m_ready = 1'b0;
        for (int k = 1; k < 4; k++)
            applyStimulus(vec5(kVal[k], 32'd0), vec5(32'h3F800000, 32'd0), kVal[k], acc);
        s_valid = 1'b0;
        repeat (10) nextCycle();
        s_valid = 1'b1; s_a = vec5(kVal[4], 32'd0); curExp = kVal[4];
        m_ready = 1'b1;
        @(negedge clk);
        checkOutput("both handshakes s_ready", {31'd0, s_ready}, 32'd1);
        checkOutput("both handshakes m_valid", {31'd0, m_valid}, 32'd1);
        nextCycle();
        s_valid = 1'b0; m_ready = 1'b0;
        nextCycle();
        @(negedge clk);
        checkOutput("credits unchanged", {31'd0, s_ready}, 32'd1);
        nextCycle();
        applyStimulus(vec5(kVal[5], 32'd0), vec5(32'h3F800000, 32'd0), kVal[5], acc);
        s_a = vec5(kVal[2], 32'd0); curExp = kVal[2];
        holdOffCheck("s_ready low at full credits", 6);
        m_ready = 1'b1;
        applyStimulus(vec5(kVal[2], 32'd0), vec5(32'h3F800000, 32'd0), kVal[2], acc);
        s_valid = 1'b0;
        waitIdle();

        $display("[TB] reset mid-op");
        applyStimulus({5{32'h3F800000}}, {5{32'h40000000}}, 32'h41200000, acc);
        s_valid = 1'b0;
        nextCycle();
        nextCycle();
        rst_n = 1'b0;
        expQ.delete();
        accQ.delete();
        headSeen = 0;
        nextCycle();
        rst_n = 1'b1;
        for (int t = 0; t < 12; t++) begin
            @(negedge clk);
            checkOutput("no result after reset", {31'd0, m_valid}, 32'd0);
            nextCycle();
        end
        checkOutput("idle after reset", {31'd0, idle}, 32'd1);

        $display("[TB] signed operands after reset");
        applyStimulus(vec5(32'hBFC00000, 32'h3F800000), vec5(32'h40000000, 32'h3F800000),
                      32'hC0000000, acc);
        s_valid = 1'b0;
        waitIdle();

        checkOutput("scoreboard drained", expQ.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule

// File: doc/pe_fp32_feeder.md
# pe_fp32_feeder

Initiator side of the 5-lane FP32 dot-product PE interface. It accepts operand vector pairs on a valid/ready stream, holds each pair on the PE's `A`/`B` inputs for two consecutive cycles with the pass-select `clk_cntr` sequence 0 then 1, and tracks the PE's fixed 4-cycle pipeline. It captures each finished FP32 result from the PE's `out` into a result FIFO and presents it on a valid/ready output stream. Issue is credit-gated, so the non-stallable PE pipeline never produces a result with no free FIFO slot.

## Interface
- `FIFO_DEPTH`, 4: result FIFO entries, and the maximum number of dot-products in flight or buffered. Power of two, at least 2.
- `PE_LATENCY`, 4: rising edges from the cycle in which the PE's inputs carry the pass-1 beat until `out` holds that beat's result.
- `clk` input 1: single clock. All logic is on its rising edge.
- `rst_n` input 1: reset. Synchronous and active-low.
- `s_valid` input 1: an operand pair is offered.
- `s_ready` output 1: the block will accept the operand pair this cycle.
- `s_a` input 160: five FP32 lanes. Lane i occupies bits [32i+31:32i].
- `s_b` input 160: five FP32 lanes, same packing as `s_a`.
- `pe_a` output 160: drives the PE's `A` input.
- `pe_b` output 160: drives the PE's `B` input.
- `pe_cntr` output 1: drives the PE's `clk_cntr` input.
- `pe_out` input 32: the PE's registered FP32 result.
- `m_valid` output 1: a result is available.
- `m_ready` input 1: the downstream stage takes the result.
- `m_data` output 32: FP32 dot-product result.
- `idle` output 1: no operation is in flight or buffered.

## Operation
- State machine with three states:
  - IDLE: `pe_cntr`=0.
  - P0: pass 0, `pe_cntr`=0.
  - P1: pass 1, `pe_cntr`=1.
- `pe_a`, `pe_b` and `pe_cntr` are registered outputs, decoded from next-state.
- Accept occurs when `s_valid` && `s_ready`.
  - `s_ready` = (state != P0) && (`credits` < FIFO_DEPTH).
  - An accept loads `s_a`/`s_b` into `pe_a`/`pe_b` and moves the FSM to P0.
- Transitions:
  - IDLE → P0 on accept.
  - P0 → P1 unconditionally.
  - P1 → P0 on accept, otherwise P1 → IDLE.
- `pe_a`/`pe_b` change only on accept. They are held through P0 and P1, and through IDLE.
- Launch tracking uses a shift register `tag[PE_LATENCY-1:0]`.
  - It shifts every cycle and inserts 1 while state==P1.
  - When the tag leaves the final stage, `pe_out` is pushed into the FIFO on that edge.
- Credits:
  - The `credits` counter increments on accept and decrements on pop (`m_valid` && `m_ready`).
  - A simultaneous accept and pop leaves it unchanged.
  - Range is 0..FIFO_DEPTH. Because of this counter, a push never finds the FIFO full.
- FIFO: `m_valid` = FIFO not empty, and `m_data` = head entry. The head is first-word-fall-through from the storage registers.
- `idle` = (`credits`==0) && (state==IDLE).
- Results leave in the same order the operand pairs were accepted.
- Results are passed through bit-exact. No FP interpretation happens here.

## Timing
- Reset values while `rst_n`=0 at a clock edge:
  - state=IDLE.
  - `pe_a`=0, `pe_b`=0, `pe_cntr`=0.
  - `tag`=0, `credits`=0, FIFO empty.
  - `s_ready`=0 during reset, `m_valid`=0, `m_data`=0, `idle`=1.
- Reset in the middle of an operation discards all in-flight and buffered results. PE pipeline contents are ignored because `tag` is cleared. The PE itself has no reset; its next pass-0 beat clears the PE accumulator.
- Accept at the end of cycle c:
  - Cycle c+1 is P0.
  - Cycle c+2 is P1.
  - The push happens at the end of cycle c+6.
  - `m_valid`=1 in cycle c+7.
  - Accept-to-result latency is therefore 7 cycles.
- Peak throughput is one accept per 2 cycles. `s_ready` is 0 in every P0 cycle.
- With `m_ready` held at 0, exactly FIFO_DEPTH accepts occur, then `s_ready`=0. A pop in cycle k lets `s_ready`=1 in cycle k+1, provided state != P0.
- `m_data` is stable while `m_valid`=1 and `m_ready`=0.

## Structure
- Shared package `pe_pkg`:
  - `PE_LANES`=5, `FP32_W`=32, `PE_VEC_W`=160, `PE_LATENCY`=4.
  - Enum `pe_pass_e` {IDLE, P0, P1}.
- One sub-module, `pe_result_fifo`: synchronous FIFO with parameter `DEPTH`, 32-bit data, push/pop, `empty`/`full`, and reset on `rst_n`.
- Top-level: FSM, operand registers, tag shift register, credit counter.

## Test plan
- Single op: all `s_a` lanes 0x3F800000 (1.0), all `s_b` lanes 0x40000000 (2.0), accepted in cycle 0 → `pe_cntr` is 0 in cycle 1 and 1 in cycle 2; `m_valid` rises in cycle 7 with `m_data`=0x41200000 (10.0); `idle` returns to 1 after the pop.
- Back-to-back with `s_valid` held high: 6 ops, op k has lane 0 = k.0 × 1.0 and the other lanes 0 → accepts occur every 2 cycles; results 0x00000000, 0x3F800000, 0x40000000, 0x40400000, 0x40800000, 0x40A00000 emerge in order, 2 cycles apart.
- Backpressure: `m_ready`=0 with 6 ops offered → exactly 4 accepted, `s_ready` stays 0; one pop → exactly one more accept, the FIFO never overflows, and order is preserved.
- Simultaneous accept and pop with `credits`=FIFO_DEPTH-1 → `credits` unchanged and both handshakes complete.
- Reset mid-op: assert `rst_n`=0 for 1 cycle, 3 cycles after an accept → no `m_valid` ever appears for that op; a new op issued after reset returns the correct value 7 cycles after its accept.
- Signed operands: lane 0 = -1.5 × 2.0, lane 1 = 1.0 × 1.0 → `m_data`=0xC0000000 (-2.0).
